// File: rtl/seventy_two_bit_pkg.sv
// Shared types and defaults for the 72-bit processor memory arbiter.
package seventy_two_bit_pkg;

  localparam int DATA_W_DEF  = 72;
  localparam int ADDR_W_DEF  = 16;
  localparam int MEM_LAT_DEF = 2;
  localparam int LAT_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Arbitration decision; rr_en selects alternation on a tie, else the LSU wins.
  function automatic owner_t pick_owner(input logic if_req, input logic d_req,
                                        input owner_t last_owner, input logic rr_en);
    owner_t w;
    if (if_req && d_req) begin
      if (rr_en) begin
        w = (last_owner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
      end else begin
        w = OWN_DATA;
      end
    end else if (d_req) begin
      w = OWN_DATA;
    end else begin
      w = OWN_FETCH;
    end
    return w;
  endfunction

endpackage

// File: rtl/seventy_two_bit_mem_arbiter.sv
// Single-port 72-bit memory arbiter between instruction fetch and the LSU.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate owners on simultaneous requests).
module seventy_two_bit_mem_arbiter
  import seventy_two_bit_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("seventy_two_bit_mem_arbiter: MEM_LAT must be within 1..15");
  end

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_t           state_q, state_d;
  owner_t               owner_q, owner_d;
  owner_t               last_owner_q, last_owner_d;
  logic                 we_q, we_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;

  logic                 if_gnt_q, if_gnt_d;
  logic                 if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]    if_rdata_q, if_rdata_d;
  logic                 d_gnt_q, d_gnt_d;
  logic                 d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]    d_rdata_q, d_rdata_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic   any_req;
  owner_t winner;
  logic   issue_we;

  assign any_req  = if_req | d_req;
  assign winner   = pick_owner(if_req, d_req, last_owner_q, RR_EN);
  assign issue_we = (winner == OWN_DATA) && d_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_FETCH;
      last_owner_q <= OWN_FETCH;
      we_q         <= 1'b0;
      lat_cnt_q    <= '0;
      if_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      d_gnt_q      <= 1'b0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      lat_cnt_q    <= lat_cnt_d;
      if_gnt_q     <= if_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_gnt_q      <= d_gnt_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // WAIT is always visited so that data capture lands exactly MEM_LAT cycles after mem_en.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    lat_cnt_d    = lat_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = ISSUE;
          owner_d      = winner;
          last_owner_d = winner;
          we_d         = issue_we;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        lat_cnt_d = LAT_INIT;
      end
      WAIT: begin
        if (lat_cnt_q == {LAT_CNT_W{1'b0}}) begin
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - {{(LAT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the transition, so they line up with the state they belong to.
  always_comb begin
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          mem_en_d    = 1'b1;
          mem_we_d    = issue_we;
          mem_addr_d  = (winner == OWN_DATA) ? d_addr : if_addr;
          mem_wdata_d = issue_we ? d_wdata : '0;
          if_gnt_d    = (winner == OWN_FETCH);
          d_gnt_d     = (winner == OWN_DATA);
        end else begin
          mem_en_d = 1'b0;
        end
      end
      WAIT: begin
        if (lat_cnt_q == {LAT_CNT_W{1'b0}}) begin
          if (owner_q == OWN_FETCH) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end else begin
            d_rvalid_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else begin
          d_rvalid_d = 1'b0;
        end
      end
      default: mem_en_d = 1'b0;
    endcase
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
